// File: rtl/screen_fill_arbiter.sv
// Shares the screen VRAM port between the CPU and a block-fill engine.
// The CPU has priority, the fill uses idle cycles, and an optional forced steal stops the CPU starving the fill.
module screen_fill_arbiter #(
   parameter int ADDR_W       = 13,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_sel,
   input  logic              cpu_load,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic [DATA_W-1:0] cpu_in,
   output logic              cpu_stall,
   input  logic              fill_start,
   input  logic              fill_abort,
   input  logic [ADDR_W-1:0] fill_base,
   input  logic [ADDR_W:0]   fill_count,
   input  logic [DATA_W-1:0] fill_value,
   output logic              busy,
   output logic              done,
   output logic              scr_load,
   output logic [ADDR_W-1:0] scr_address,
   output logic [DATA_W-1:0] scr_in
);

   localparam int CNT_W    = ADDR_W + 1;
   localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam bit STEAL_EN = (STARVE_LIMIT > 0);
   localparam logic [CNT_W-1:0]    MAX_COUNT  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]    remaining_q, remaining_d;
   logic [DATA_W-1:0]   value_q, value_d;
   logic [STARVE_W-1:0] starve_q, starve_d;

   logic                fill_grant;
   logic                steal;
   logic [CNT_W-1:0]    count_clamped;

   assign count_clamped = (fill_count > MAX_COUNT) ? MAX_COUNT : fill_count;
   assign steal         = STEAL_EN && (starve_q == STARVE_MAX);

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         remaining_q <= '0;
         value_q     <= '0;
         starve_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         remaining_q <= remaining_d;
         value_q     <= value_d;
         starve_q    <= starve_d;
      end
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d     = state_q;
      ptr_d       = ptr_q;
      remaining_d = remaining_q;
      value_d     = value_q;
      starve_d    = starve_q;
      fill_grant  = 1'b0;
      cpu_stall   = 1'b0;
      case (state_q)
         S_IDLE: begin
            starve_d = '0;
            if (fill_start && !fill_abort) begin
               ptr_d       = fill_base;
               value_d     = fill_value;
               remaining_d = count_clamped;
               state_d     = (count_clamped == '0) ? S_DONE : S_FILL;
            end
         end
         S_FILL: begin
            // Abort outranks both a normal grant and a forced steal.
            if (fill_abort) begin
               state_d  = S_IDLE;
               starve_d = '0;
            end else if (!cpu_sel || steal) begin
               fill_grant  = 1'b1;
               cpu_stall   = cpu_sel;
               ptr_d       = ptr_q + ADDR_W'(1);
               remaining_d = remaining_q - CNT_W'(1);
               starve_d    = '0;
               if (remaining_q == CNT_W'(1)) begin
                  state_d = S_DONE;
               end
            end else if (STEAL_EN) begin
               starve_d = starve_q + STARVE_W'(1);
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Zero-latency mux keeps CPU reads through the screen same-cycle.
   assign scr_load    = fill_grant ? 1'b1    : (cpu_load & cpu_sel);
   assign scr_address = fill_grant ? ptr_q   : cpu_address;
   assign scr_in      = fill_grant ? value_q : cpu_in;

   assign busy = (state_q == S_FILL);
   assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_screen_fill_arbiter.sv
// Self-checking bench: a no-steal and a steal (limit 2) arbiter share stimulus.
// Each is checked per cycle against a write schedule planned from the fill rules.
module tb_screen_fill_arbiter;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int MAXH   = 8400;

   typedef struct packed {
      logic              load;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              stall;
      logic              busy;
      logic              done;
   } obs_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              cpu_sel, cpu_load;
   logic [ADDR_W-1:0] cpu_address;
   logic [DATA_W-1:0] cpu_in;
   logic              fill_start, fill_abort;
   logic [ADDR_W-1:0] fill_base;
   logic [ADDR_W:0]   fill_count;
   logic [DATA_W-1:0] fill_value;

   logic [1:0]             cpu_stall, busy, done, scr_load;
   logic [1:0][ADDR_W-1:0] scr_address;
   logic [1:0][DATA_W-1:0] scr_in;

   int total = 0;
   int bad   = 0;
   int lim [2] = '{0, 2};

   logic [DATA_W-1:0] vram    [2][DEPTH];
   logic [DATA_W-1:0] exp_mem [2][DEPTH];

   bit                st_sel  [MAXH];
   bit                st_ld   [MAXH];
   logic [ADDR_W-1:0] st_addr [MAXH];
   logic [DATA_W-1:0] st_data [MAXH];
   bit                st_ms   [MAXH];

   bit                pl_wr    [2][MAXH];
   bit                pl_stall [2][MAXH];
   logic [ADDR_W-1:0] pl_addr  [2][MAXH];
   int                pl_end   [2];
   int                pl_done  [2];

   always #5 clk = ~clk;

   screen_fill_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(0)) dut_nosteal (
      .clk(clk), .reset(reset),
      .cpu_sel(cpu_sel), .cpu_load(cpu_load), .cpu_address(cpu_address), .cpu_in(cpu_in),
      .cpu_stall(cpu_stall[0]),
      .fill_start(fill_start), .fill_abort(fill_abort), .fill_base(fill_base),
      .fill_count(fill_count), .fill_value(fill_value),
      .busy(busy[0]), .done(done[0]),
      .scr_load(scr_load[0]), .scr_address(scr_address[0]), .scr_in(scr_in[0])
   );

   screen_fill_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(2)) dut_steal (
      .clk(clk), .reset(reset),
      .cpu_sel(cpu_sel), .cpu_load(cpu_load), .cpu_address(cpu_address), .cpu_in(cpu_in),
      .cpu_stall(cpu_stall[1]),
      .fill_start(fill_start), .fill_abort(fill_abort), .fill_base(fill_base),
      .fill_count(fill_count), .fill_value(fill_value),
      .busy(busy[1]), .done(done[1]),
      .scr_load(scr_load[1]), .scr_address(scr_address[1]), .scr_in(scr_in[1])
   );

   // Shadow screens capture whatever each arbiter actually writes.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (scr_load[d]) vram[d][scr_address[d]] <= scr_in[d];
      end
   end

   // mode: 0 CPU idle, 1 alternate (busy on odd cycles), 2 held busy, 3 random
   task automatic gen_stim(input int mode);
      for (int k = 0; k < MAXH; k++) begin
         case (mode)
            0:       st_sel[k] = 1'b0;
            1:       st_sel[k] = ((k % 2) == 1);
            2:       st_sel[k] = 1'b1;
            default: st_sel[k] = ($urandom_range(0, 1) == 1);
         endcase
         st_ld[k]   = ($urandom_range(0, 1) == 1);
         st_addr[k] = ADDR_W'($urandom);
         st_data[k] = DATA_W'($urandom);
         st_ms[k]   = ($urandom_range(0, 3) == 0);
      end
   endtask

   // Walk the cycles after a start and decide, from the arbitration rules alone,
   // which cycles each arbiter spends writing fill words.
   task automatic plan(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] count, input int abort_k);
      int left, written, blocked;
      left = (int'(count) > DEPTH) ? DEPTH : int'(count);
      for (int d = 0; d < 2; d++) begin
         written    = 0;
         blocked    = 0;
         pl_end[d]  = 0;
         pl_done[d] = -1;
         for (int k = 0; k < MAXH; k++) begin
            pl_wr[d][k]    = 1'b0;
            pl_stall[d][k] = 1'b0;
            pl_addr[d][k]  = '0;
         end
         if (left == 0) begin
            pl_done[d] = 1;
         end else begin
            for (int k = 1; k < MAXH - 8; k++) begin
               if (k == abort_k) begin
                  pl_end[d] = k;
                  break;
               end
               if (!st_sel[k] || (lim[d] > 0 && blocked == lim[d])) begin
                  pl_wr[d][k]    = 1'b1;
                  pl_stall[d][k] = st_sel[k];
                  pl_addr[d][k]  = ADDR_W'((int'(base) + written) % DEPTH);
                  written++;
                  blocked = 0;
                  if (written == left) begin
                     pl_end[d]  = k;
                     pl_done[d] = k + 1;
                     break;
                  end
               end else begin
                  blocked++;
               end
            end
         end
      end
   endtask

   task automatic run_fill(input string name, input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] count,
                           input logic [DATA_W-1:0] value, input int abort_k, input int tail);
      int   last0, last1, horizon, first_end;
      obs_t exp_o, got;
      plan(base, count, abort_k);
      last0     = (pl_done[0] > 0) ? pl_done[0] : pl_end[0];
      last1     = (pl_done[1] > 0) ? pl_done[1] : pl_end[1];
      horizon   = ((last0 > last1) ? last0 : last1) + tail;
      first_end = (last0 < last1) ? last0 : last1;
      for (int k = 0; k <= horizon; k++) begin
         @(negedge clk);
         cpu_sel     = st_sel[k];
         cpu_load    = st_ld[k];
         cpu_address = st_addr[k];
         cpu_in      = st_data[k];
         fill_abort  = (abort_k > 0) && (k == abort_k);
         if (k == 0) begin
            fill_start = 1'b1;
            fill_base  = base;
            fill_count = count;
            fill_value = value;
         end else begin
            fill_start = st_ms[k] && (k <= first_end);
            fill_base  = ADDR_W'($urandom);
            fill_count = (ADDR_W + 1)'($urandom);
            fill_value = DATA_W'($urandom);
         end
         #1;
         for (int d = 0; d < 2; d++) begin
            exp_o.busy = (k >= 1) && (k <= pl_end[d]);
            exp_o.done = (k == pl_done[d]);
            if (pl_wr[d][k]) begin
               exp_o.load  = 1'b1;
               exp_o.addr  = pl_addr[d][k];
               exp_o.data  = value;
               exp_o.stall = pl_stall[d][k];
            end else begin
               exp_o.load  = cpu_sel & cpu_load;
               exp_o.addr  = cpu_address;
               exp_o.data  = cpu_in;
               exp_o.stall = 1'b0;
            end
            got = {scr_load[d], scr_address[d], scr_in[d], cpu_stall[d], busy[d], done[d]};
            total++;
            if (got !== exp_o) begin
               bad++;
               $display("FAIL %s dut%0d cycle %0d: got load=%b addr=%0d data=%h stall=%b busy=%b done=%b, want load=%b addr=%0d data=%h stall=%b busy=%b done=%b",
                        name, d, k, got.load, got.addr, got.data, got.stall, got.busy, got.done,
                        exp_o.load, exp_o.addr, exp_o.data, exp_o.stall, exp_o.busy, exp_o.done);
            end
            if (exp_o.load) exp_mem[d][exp_o.addr] = exp_o.data;
         end
      end
   endtask

   task automatic check_mem(input string name);
      int diffs;
      @(negedge clk);
      cpu_sel    = 1'b0;
      cpu_load   = 1'b0;
      fill_start = 1'b0;
      fill_abort = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         diffs = 0;
         for (int i = 0; i < DEPTH; i++) begin
            if (vram[d][i] !== exp_mem[d][i]) diffs++;
         end
         total++;
         if (diffs != 0) begin
            bad++;
            $display("FAIL %s_mem dut%0d: %0d words differ from expected screen, want 0", name, d, diffs);
         end
      end
   endtask

   task automatic test_reset();
      obs_t exp_o, got;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cpu_sel     = ($urandom_range(0, 1) == 1);
         cpu_load    = ($urandom_range(0, 1) == 1);
         cpu_address = ADDR_W'($urandom);
         cpu_in      = DATA_W'($urandom);
         fill_start  = 1'b1;
         fill_count  = 14'd5;
         #1;
         for (int d = 0; d < 2; d++) begin
            exp_o = {cpu_sel & cpu_load, cpu_address, cpu_in, 1'b0, 1'b0, 1'b0};
            got   = {scr_load[d], scr_address[d], scr_in[d], cpu_stall[d], busy[d], done[d]};
            total++;
            if (got !== exp_o) begin
               bad++;
               $display("FAIL reset_state dut%0d: got %h want %h", d, got, exp_o);
            end
            if (exp_o.load) exp_mem[d][exp_o.addr] = exp_o.data;
         end
      end
      @(negedge clk);
      reset      = 1'b0;
      fill_start = 1'b0;
      cpu_sel    = 1'b0;
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         total++;
         if (busy[d] !== 1'b0 || done[d] !== 1'b0) begin
            bad++;
            $display("FAIL reset_release dut%0d: got busy=%b done=%b want 0 0", d, busy[d], done[d]);
         end
      end
   endtask

   task automatic test_full_clear();
      gen_stim(0);
      run_fill("full_clear", '0, 14'd8192, 16'h0000, 0, 2);
      check_mem("full_clear");
   endtask

   task automatic test_wrap();
      @(negedge clk);
      cpu_sel     = 1'b1;
      cpu_load    = 1'b1;
      cpu_address = 13'd2;
      cpu_in      = 16'h1234;
      fill_start  = 1'b0;
      fill_abort  = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         total++;
         if (scr_load[d] !== 1'b1 || scr_address[d] !== 13'd2 || scr_in[d] !== 16'h1234) begin
            bad++;
            $display("FAIL cpu_write dut%0d: got load=%b addr=%0d data=%h want 1 2 1234",
                     d, scr_load[d], scr_address[d], scr_in[d]);
         end
         exp_mem[d][2] = 16'h1234;
      end
      gen_stim(0);
      run_fill("wrap", 13'd8190, 14'd4, 16'hFFFF, 0, 2);
      check_mem("wrap");
      for (int d = 0; d < 2; d++) begin
         total++;
         if (vram[d][2] !== 16'h1234) begin
            bad++;
            $display("FAIL wrap_untouched dut%0d: word 2 got %h want 1234", d, vram[d][2]);
         end
         for (int i = 0; i < 4; i++) begin
            int a;
            a = (8190 + i) % DEPTH;
            total++;
            if (vram[d][a] !== 16'hFFFF) begin
               bad++;
               $display("FAIL wrap_word dut%0d: word %0d got %h want ffff", d, a, vram[d][a]);
            end
         end
      end
   endtask

   task automatic test_alternate();
      gen_stim(1);
      run_fill("alternate", ADDR_W'($urandom), 14'd3, DATA_W'($urandom), 0, 2);
   endtask

   task automatic test_starve();
      gen_stim(2);
      run_fill("starve", ADDR_W'($urandom), 14'd4, DATA_W'($urandom), 14, 2);
   endtask

   task automatic test_abort();
      gen_stim(0);
      run_fill("abort", ADDR_W'($urandom), 14'd10, DATA_W'($urandom), 6, 0);
      gen_stim(0);
      run_fill("restart", ADDR_W'($urandom), 14'd5, DATA_W'($urandom), 0, 2);
      check_mem("abort");
   endtask

   task automatic test_start_abort_idle();
      @(negedge clk);
      cpu_sel    = 1'b0;
      fill_start = 1'b1;
      fill_abort = 1'b1;
      fill_count = 14'd5;
      @(negedge clk);
      fill_start = 1'b0;
      fill_abort = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         total++;
         if (busy[d] !== 1'b0 || done[d] !== 1'b0 || scr_load[d] !== 1'b0) begin
            bad++;
            $display("FAIL start_abort_idle dut%0d: got busy=%b done=%b load=%b want 0 0 0",
                     d, busy[d], done[d], scr_load[d]);
         end
      end
   endtask

   task automatic test_clamp();
      gen_stim(0);
      run_fill("clamp", ADDR_W'($urandom), 14'h3FFF, DATA_W'($urandom), 0, 2);
      check_mem("clamp");
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         logic [ADDR_W-1:0] base;
         logic [ADDR_W:0]   count;
         int                ab, min_end;
         base  = ADDR_W'($urandom);
         count = (ADDR_W + 1)'($urandom_range(1, 40));
         gen_stim(3);
         plan(base, count, 0);
         min_end = (pl_end[0] < pl_end[1]) ? pl_end[0] : pl_end[1];
         ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, min_end) : 0;
         run_fill("random", base, count, DATA_W'($urandom), ab, 2);
      end
      check_mem("random");
   endtask

   task automatic test_reset_mid();
      logic [ADDR_W-1:0] base;
      logic [DATA_W-1:0] value;
      base  = ADDR_W'($urandom);
      value = DATA_W'($urandom);
      @(negedge clk);
      cpu_sel    = 1'b0;
      fill_abort = 1'b0;
      fill_start = 1'b1;
      fill_base  = base;
      fill_count = 14'd20;
      fill_value = value;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         fill_start = 1'b0;
         #1;
         for (int d = 0; d < 2; d++) begin
            total++;
            if (busy[d] !== 1'b1 || scr_load[d] !== 1'b1 || scr_address[d] !== ADDR_W'(base + i) || scr_in[d] !== value) begin
               bad++;
               $display("FAIL reset_mid_fill dut%0d word %0d: got busy=%b load=%b addr=%0d data=%h want 1 1 %0d %h",
                        d, i, busy[d], scr_load[d], scr_address[d], scr_in[d], ADDR_W'(base + i), value);
            end
            exp_mem[d][ADDR_W'(base + i)] = value;
         end
      end
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         total++;
         if (busy[d] !== 1'b0 || done[d] !== 1'b0 || scr_load[d] !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_now dut%0d: got busy=%b done=%b load=%b want 0 0 0", d, busy[d], done[d], scr_load[d]);
         end
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (c == 1) reset = 1'b0;
         #1;
         for (int d = 0; d < 2; d++) begin
            total++;
            if (busy[d] !== 1'b0 || done[d] !== 1'b0 || scr_load[d] !== 1'b0) begin
               bad++;
               $display("FAIL reset_mid_after dut%0d cycle %0d: got busy=%b done=%b load=%b want 0 0 0",
                        d, c, busy[d], done[d], scr_load[d]);
            end
         end
      end
      gen_stim(0);
      run_fill("zero_count", ADDR_W'($urandom), 14'd0, DATA_W'($urandom), 0, 2);
      check_mem("reset_mid");
   endtask

   initial begin
      reset       = 1'b1;
      cpu_sel     = 1'b0;
      cpu_load    = 1'b0;
      cpu_address = '0;
      cpu_in      = '0;
      fill_start  = 1'b0;
      fill_abort  = 1'b0;
      fill_base   = '0;
      fill_count  = '0;
      fill_value  = '0;
      test_reset();
      test_full_clear();
      test_wrap();
      test_alternate();
      test_starve();
      test_abort();
      test_start_abort_idle();
      test_clamp();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
